// File: rtl/memory_bus_pkg.sv
// Shared constants for the memory bus: FSM state encodings, bank
// decode values (address bits [15:14]) and the default wait-state count.
package memory_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] BANK_RAM    = 2'b00;
    localparam logic [1:0] BANK_ROM    = 2'b01;
    localparam logic [1:0] BANK_PERIPH = 2'b10;
    localparam logic [1:0] BANK_BRAM   = 2'b11;

    localparam int DEF_WAIT_STATES = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin winner select (combinational).
// Ports: req_0/req_1 requests, grant = last winner, lock_hold (only with
// ARB_LOCK_EN) keeps the last winner; any = some request, winner = index.
module rr_arbiter2 (
    input  logic req_0,
    input  logic req_1,
    input  logic grant,
`ifdef ARB_LOCK_EN
    input  logic lock_hold,
`endif
    output logic any,
    output logic winner
);

    logic req_last;

    assign req_last = grant ? req_1 : req_0;

    always_comb begin
        any    = req_0 | req_1;
        winner = req_1;
`ifdef ARB_LOCK_EN
        if (lock_hold && req_last) begin
            winner = grant;
        end else if (req_0 && req_1) begin
            winner = ~grant;
        end
`else
        if (req_0 && req_1) begin
            winner = ~grant;
        end
`endif
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-port arbiter/sequencer in front of memory_bus (port 0 CPU, port 1 DMA).
// Ports: req/we/addr/wdata/wmask per port in, ack/rdata per port out,
// bus_* to memory_bus, bus_data_out from it, grant = current/last winner.
// Macro ARB_LOCK_EN adds lock_0/lock_1 for atomic back-to-back grants.
module memory_bus_arbiter
    import memory_bus_pkg::*;
#(
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_0,
    input  logic                    req_1,
    input  logic                    we_0,
    input  logic                    we_1,
    input  logic [ADDR_WIDTH-1:0]   addr_0,
    input  logic [ADDR_WIDTH-1:0]   addr_1,
    input  logic [DATA_WIDTH-1:0]   wdata_0,
    input  logic [DATA_WIDTH-1:0]   wdata_1,
    input  logic [DATA_WIDTH/8-1:0] wmask_0,
    input  logic [DATA_WIDTH/8-1:0] wmask_1,
`ifdef ARB_LOCK_EN
    input  logic                    lock_0,
    input  logic                    lock_1,
`endif
    output logic                    ack_0,
    output logic                    ack_1,
    output logic [DATA_WIDTH-1:0]   rdata_0,
    output logic [DATA_WIDTH-1:0]   rdata_1,
    output logic [ADDR_WIDTH-1:0]   bus_address,
    output logic [DATA_WIDTH-1:0]   bus_data_in,
    output logic [DATA_WIDTH/8-1:0] bus_write_mask,
    output logic                    bus_enable,
    output logic                    bus_write_enable,
    input  logic [DATA_WIDTH-1:0]   bus_data_out,
    output logic                    grant
);

    state_t                  state, next_state;
    logic [3:0]              cnt;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wmask_q;
    logic                    any;
    logic                    winner;
    logic                    last;

    assign last = (cnt == 4'd0);

`ifdef ARB_LOCK_EN
    logic lock_hold;
    logic lock_g;

    assign lock_g = grant ? lock_1 : lock_0;
`endif

    rr_arbiter2 u_rr (
        .req_0     (req_0),
        .req_1     (req_1),
        .grant     (grant),
`ifdef ARB_LOCK_EN
        .lock_hold (lock_hold & lock_g),
`endif
        .any       (any),
        .winner    (winner)
    );

    // Bus outputs are gated by state so an async reset clears them at once.
    always_comb begin
        next_state       = state;
        bus_enable       = 1'b0;
        bus_write_enable = 1'b0;
        bus_address      = '0;
        bus_data_in      = '0;
        bus_write_mask   = '0;
        ack_0            = 1'b0;
        ack_1            = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any) next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                bus_enable       = 1'b1;
                bus_address      = addr_q;
                bus_data_in      = wdata_q;
                bus_write_mask   = wmask_q;
                // single write strobe, final access cycle only
                bus_write_enable = last & we_q;
                if (last) next_state = ST_DONE;
            end
            ST_DONE: begin
                ack_0      = ~grant;
                ack_1      = grant;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_0 <= '0;
            rdata_1 <= '0;
            grant   <= 1'b1;
`ifdef ARB_LOCK_EN
            lock_hold <= 1'b0;
`endif
        end else begin
            state <= next_state;
            unique case (state)
                ST_IDLE: begin
`ifdef ARB_LOCK_EN
                    lock_hold <= 1'b0;
`endif
                    if (any) begin
                        grant   <= winner;
                        we_q    <= winner ? we_1 : we_0;
                        addr_q  <= winner ? addr_1 : addr_0;
                        wdata_q <= winner ? wdata_1 : wdata_0;
                        wmask_q <= winner ? wmask_1 : wmask_0;
                        cnt     <= 4'(WAIT_STATES);
                    end
                end
                ST_ACCESS: begin
                    if (!last) begin
                        cnt <= cnt - 4'd1;
                    end else if (!we_q) begin
                        if (grant) rdata_1 <= bus_data_out;
                        else       rdata_0 <= bus_data_out;
                    end
                end
                ST_DONE: begin
`ifdef ARB_LOCK_EN
                    lock_hold <= lock_g;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: three instances (WAIT_STATES 1, 0, 15)
// share stimulus; most checks target the WAIT_STATES=1 instance.
module tb_memory_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_0 = 1'b0, req_1 = 1'b0;
    logic        we_0 = 1'b0, we_1 = 1'b0;
    logic [15:0] addr_0 = '0, addr_1 = '0;
    logic [31:0] wdata_0 = '0, wdata_1 = '0;
    logic [3:0]  wmask_0 = '0, wmask_1 = '0;
    logic [31:0] bus_data_out = '0;
`ifdef ARB_LOCK_EN
    logic        lock_0 = 1'b0, lock_1 = 1'b0;
`endif

    logic        ack_0 [3];
    logic        ack_1 [3];
    logic        grant [3];
    logic        bus_en [3];
    logic        bus_we [3];
    logic [31:0] rdata_0 [3];
    logic [31:0] rdata_1 [3];
    logic [31:0] bus_din [3];
    logic [15:0] bus_addr [3];
    logic [3:0]  bus_mask [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        memory_bus_arbiter #(
            .WAIT_STATES (k == 0 ? 1 : (k == 1 ? 0 : 15)),
            .ADDR_WIDTH  (16),
            .DATA_WIDTH  (32)
        ) dut (
            .clk              (clk),
            .reset            (rst_n),
            .req_0            (req_0),
            .req_1            (req_1),
            .we_0             (we_0),
            .we_1             (we_1),
            .addr_0           (addr_0),
            .addr_1           (addr_1),
            .wdata_0          (wdata_0),
            .wdata_1          (wdata_1),
            .wmask_0          (wmask_0),
            .wmask_1          (wmask_1),
`ifdef ARB_LOCK_EN
            .lock_0           (lock_0),
            .lock_1           (lock_1),
`endif
            .ack_0            (ack_0[k]),
            .ack_1            (ack_1[k]),
            .rdata_0          (rdata_0[k]),
            .rdata_1          (rdata_1[k]),
            .bus_address      (bus_addr[k]),
            .bus_data_in      (bus_din[k]),
            .bus_write_mask   (bus_mask[k]),
            .bus_enable       (bus_en[k]),
            .bus_write_enable (bus_we[k]),
            .bus_data_out     (bus_data_out),
            .grant            (grant[k])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_0 = 1'b0;
        req_1 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] dout;
        logic [31:0] exp_r0;
        logic [31:0] exp_r1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat, wcnt, oth, got, bad, acc;
        int l1, l2, nack;
        logic [15:0] wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        int ord [4];
        int tim [4];

        vecs[0] = '{1'b0, 1'b0, 16'h4004, 32'h0, 4'h0,
                    32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 16'h8010, 32'h000000A5, 4'b0001,
                    32'h11111111, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 16'hC020, 32'h0, 4'h0,
                    32'h12345678, 32'hDEADBEEF, 32'h12345678};
        vecs[3] = '{1'b0, 1'b1, 16'h0008, 32'hFFFF0000, 4'b1100,
                    32'h55555555, 32'hDEADBEEF, 32'h12345678};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 32'h0, 4'h0,
                    32'hCAFEF00D, 32'hCAFEF00D, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 32'h0, 4'h0,
                    32'h00000000, 32'hCAFEF00D, 32'h00000000};

        // reset state
        @(negedge clk);
        chk("rst_grant", 32'(grant[0]), 32'd1);
        chk("rst_en", 32'(bus_en[0]), 32'd0);
        chk("rst_ack", 32'({ack_0[0], ack_1[0]}), 32'd0);
        chk("rst_rdata", rdata_0[0] | rdata_1[0], 32'd0);
        rst_n = 1'b1;

        // reset in the middle of a port 0 write
        @(negedge clk);
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 16'h1234;
        wdata_0 = 32'hA5A5A5A5; wmask_0 = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("mid_en", 32'(bus_en[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_en", 32'(bus_en[0]), 32'd0);
        chk("abort_bus", 32'(bus_addr[0]) | bus_din[0] | 32'(bus_mask[0]), 32'd0);
        chk("abort_we", 32'(bus_we[0]), 32'd0);
        req_0 = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if (bus_we[0] || ack_0[0] || ack_1[0]) bad++;
        end
        chk("abort_quiet", bad, 0);

        // single-port transaction table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_0 = !vecs[i].port;
            req_1 = vecs[i].port;
            we_0 = vecs[i].we; we_1 = vecs[i].we;
            addr_0 = vecs[i].addr; addr_1 = vecs[i].addr;
            wdata_0 = vecs[i].wdata; wdata_1 = vecs[i].wdata;
            wmask_0 = vecs[i].wmask; wmask_1 = vecs[i].wmask;
            bus_data_out = vecs[i].dout;
            lat = 0; wcnt = 0; oth = 0; got = 0;
            wa = '0; wd = '0; wm = '0;
            while (got == 0 && lat < 40) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
                if (bus_we[0]) begin
                    wcnt++;
                    wa = bus_addr[0]; wd = bus_din[0]; wm = bus_mask[0];
                end
                if (vecs[i].port ? ack_0[0] : ack_1[0]) oth++;
                if (vecs[i].port ? ack_1[0] : ack_0[0]) got = 1;
            end
            req_0 = 1'b0;
            req_1 = 1'b0;
            chk($sformatf("v%0d_lat", i), lat, 3);
            chk($sformatf("v%0d_grant", i), 32'(grant[0]), 32'(vecs[i].port));
            chk($sformatf("v%0d_wcnt", i), wcnt, 32'(vecs[i].we));
            chk($sformatf("v%0d_oth", i), oth, 0);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_waddr", i), 32'(wa), 32'(vecs[i].addr));
                chk($sformatf("v%0d_wdata", i), wd, vecs[i].wdata);
                chk($sformatf("v%0d_wmask", i), 32'(wm), 32'(vecs[i].wmask));
            end
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_ack1cyc", i), 32'(ack_0[0] | ack_1[0]), 32'd0);
            chk($sformatf("v%0d_r0", i), rdata_0[0], vecs[i].exp_r0);
            chk($sformatf("v%0d_r1", i), rdata_1[0], vecs[i].exp_r1);
        end

        // both ports requesting: strict alternation, ack every 4 cycles
        do_reset();
        we_0 = 1'b0; we_1 = 1'b0;
        bus_data_out = 32'h0BADF00D;
        req_0 = 1'b1;
        req_1 = 1'b1;
        nack = 0;
        for (int c = 1; c <= 60 && nack < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_0[0] || ack_1[0]) begin
                ord[nack] = ack_1[0] ? 1 : 0;
                tim[nack] = c;
                nack++;
            end
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        chk("rr_nack", nack, 4);
        if (nack == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("rr_order%0d", i), ord[i], i % 2);
            for (int i = 1; i < 4; i++)
                chk($sformatf("rr_gap%0d", i), tim[i] - tim[i-1], 4);
        end

        // latency for WAIT_STATES 0 and 15, address stability
        do_reset();
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 16'h4004;
        bus_data_out = 32'h600DCAFE;
        l1 = 0; l2 = 0; bad = 0; acc = 0;
        for (int c = 1; c <= 40 && l2 == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (l1 == 0 && ack_0[1]) l1 = c;
            if (ack_0[2]) l2 = c;
            if (bus_en[2]) begin
                acc++;
                if (bus_addr[2] !== 16'h4004) bad++;
            end
        end
        req_0 = 1'b0;
        chk("ws0_lat", l1, 2);
        chk("ws15_lat", l2, 17);
        chk("ws15_acc", acc, 16);
        chk("ws15_addr", bad, 0);
        chk("ws15_rdata", rdata_0[2], 32'h600DCAFE);

`ifdef ARB_LOCK_EN
        // port 1 locks for three transactions while port 0 waits
        do_reset();
        req_1 = 1'b1; lock_1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_0 = 1'b1;
        nack = 0;
        for (int c = 1; c <= 80 && nack < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_0[0] || ack_1[0]) begin
                ord[nack] = ack_1[0] ? 1 : 0;
                nack++;
                if (nack == 3) lock_1 = 1'b0;
            end
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        chk("lock_nack", nack, 4);
        if (nack == 4) begin
            chk("lock_o0", ord[0], 1);
            chk("lock_o1", ord[1], 1);
            chk("lock_o2", ord[2], 1);
            chk("lock_o3", ord[3], 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
